// File: rtl/reg_access_ctrl_if.sv
// Command, response and register-file signals of the register access controller.
// The master modport is the controller; the slave modport is decode, consumer and register file.
interface reg_access_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic          rsp_carry;
  logic [DW-1:0] rf_din;
  logic [AW-1:0] rf_wr_addr;
  logic          rf_wr_E;
  logic [AW-1:0] rf_rd_addr_a;
  logic [AW-1:0] rf_rd_addr_b;
  logic [DW-1:0] rf_out_a;
  logic [DW-1:0] rf_out_b;

  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds its payload stable from valid rising until that edge.
  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, rsp_ready, rf_out_a, rf_out_b,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry,
    output rf_din, rf_wr_addr, rf_wr_E, rf_rd_addr_a, rf_rd_addr_b
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, rsp_ready, rf_out_a, rf_out_b,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry,
    input  rf_din, rf_wr_addr, rf_wr_E, rf_rd_addr_a, rf_rd_addr_b
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Register access controller: one command at a time, read two operands, ALU op, write back, respond.
// Optional R0_HARDWIRED_EN makes register 0 read as zero and ignore writes.
module reg_access_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  reg_access_ctrl_if.master bus,
  output logic [2:0]        o_dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_imm, r_opa, r_opb, r_result;
  logic          r_carry;
  logic          r_cmd_ready, r_rsp_valid, r_rsp_zero, r_rsp_carry, r_rf_wr_e;
  logic [DW-1:0] r_rsp_data, r_rf_din;
  logic [AW-1:0] r_rf_wr_addr, r_rd_addr_a, r_rd_addr_b;

  logic          w_accept;
  logic [DW-1:0] w_opa, w_opb, w_result;
  logic [DW:0]   w_sum, w_diff;
  logic          w_carry, w_we;

  assign w_accept = (r_state == S_IDLE) && bus.cmd_valid && r_cmd_ready;

`ifdef R0_HARDWIRED_EN
  assign w_opa = (r_rd_addr_a == '0) ? '0 : bus.rf_out_a;
  assign w_opb = (r_rd_addr_b == '0) ? '0 : bus.rf_out_b;
`else
  assign w_opa = bus.rf_out_a;
  assign w_opb = bus.rf_out_b;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Widened by one bit so the top bit is ADD carry-out / SUB borrow (a < b unsigned).
  assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (r_op)
      3'b001:  w_result = r_imm;
      3'b010:  w_result = r_opa;
      3'b011:  begin w_result = w_sum[DW-1:0];  w_carry = w_sum[DW];  end
      3'b100:  begin w_result = w_diff[DW-1:0]; w_carry = w_diff[DW]; end
      3'b101:  w_result = r_opa & r_opb;
      3'b110:  w_result = r_opa | r_opb;
      3'b111:  w_result = r_opa;
      default: w_result = '0;
    endcase
  end

`ifdef R0_HARDWIRED_EN
  assign w_we = (r_op != 3'b000) && (r_op != 3'b111) && (r_rd != '0);
`else
  assign w_we = (r_op != 3'b000) && (r_op != 3'b111);
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_op         <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_result     <= '0;
      r_carry      <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_rf_din     <= '0;
      r_rf_wr_addr <= '0;
      r_rf_wr_e    <= 1'b0;
      r_rd_addr_a  <= '0;
      r_rd_addr_b  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op        <= bus.cmd_op;
          r_rd        <= bus.cmd_rd;
          r_imm       <= bus.cmd_imm;
          r_rd_addr_a <= bus.cmd_ra;
          r_rd_addr_b <= bus.cmd_rb;
          r_cmd_ready <= 1'b0;
        end
        S_READ: begin
          r_opa <= w_opa;
          r_opb <= w_opb;
        end
        S_EXEC: begin
          r_result     <= w_result;
          r_carry      <= w_carry;
          r_rf_din     <= w_result;
          r_rf_wr_addr <= r_rd;
          r_rf_wr_e    <= w_we;
        end
        S_WB: begin
          r_rf_wr_e   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= r_result;
          r_rsp_zero  <= (r_result == '0);
          r_rsp_carry <= r_carry;
        end
        S_RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_carry    = r_rsp_carry;
  assign bus.rf_din       = r_rf_din;
  assign bus.rf_wr_addr   = r_rf_wr_addr;
  assign bus.rf_wr_E      = r_rf_wr_e;
  assign bus.rf_rd_addr_a = r_rd_addr_a;
  assign bus.rf_rd_addr_b = r_rd_addr_b;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural 8x16 register file on the rf ports.
module tb_reg_access_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [2:0] dbg_state;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         wr_total = 0;
  logic [DW-1:0] rf [8];

  reg_access_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  reg_access_ctrl #(.DW(DW), .AW(AW)) dut (
    .CLK(clk),
    .CLR(clr),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign bus.rf_out_a = rf[bus.rf_rd_addr_a];
  assign bus.rf_out_b = rf[bus.rf_rd_addr_b];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rf_wr_E === 1'b1) begin
      rf[bus.rf_wr_addr] <= bus.rf_din;
      wr_total <= wr_total + 1;
    end
  end

  // Observations of the last command run through run_cmd
  logic [DW-1:0] obs_data, obs_we_din;
  logic          obs_zero, obs_carry;
  logic [AW-1:0] obs_we_addr;
  int            obs_we_cnt, obs_we_lat, obs_lat, acc_cyc;

  localparam logic [2:0] OP_NOP = 3'b000, OP_LDI = 3'b001, OP_MOV = 3'b010, OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100, OP_AND = 3'b101, OP_OR = 3'b110, OP_RD = 3'b111;

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                          input logic [AW-1:0] rb, input logic [DW-1:0] imm);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_cmd_timeout cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic [DW-1:0] imm);
    int n;
    send_cmd(op, rd, ra, rb, imm);
    obs_we_cnt = 0; obs_we_lat = -1; obs_lat = -1;
    obs_we_addr = '0; obs_we_din = '0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.rf_wr_E === 1'b1) begin
        obs_we_cnt++;
        if (obs_we_lat < 0) obs_we_lat = n;
        obs_we_addr = bus.rf_wr_addr;
        obs_we_din  = bus.rf_din;
      end
      if (bus.rsp_valid === 1'b1) begin
        obs_lat = n;
        break;
      end
    end
    if (obs_lat < 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout rsp_valid=%b required 1 within 20 cycles", bus.rsp_valid);
    end
    obs_data = bus.rsp_data; obs_zero = bus.rsp_zero; obs_carry = bus.rsp_carry;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rf_wr_E !== 1'b0) begin bad++; $display("FAIL reset_rf_wr_E got=%b exp=0", bus.rf_wr_E); end
    total++; if (bus.rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0000", bus.rsp_data); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    clr = 1'b0;
  endtask

  task automatic test_ldi();
    run_cmd(OP_LDI, 3'd3, 3'd0, 3'd0, 16'h1234);
    total++; if (obs_we_cnt != 1) begin bad++; $display("FAIL ldi_we_cnt got=%0d exp=1", obs_we_cnt); end
    total++; if (obs_we_lat != 2) begin bad++; $display("FAIL ldi_we_lat got=%0d exp=2", obs_we_lat); end
    total++; if (obs_we_addr !== 3'd3 || obs_we_din !== 16'h1234) begin bad++; $display("FAIL ldi_wb got=%0d/%h exp=3/1234", obs_we_addr, obs_we_din); end
    total++; if (obs_lat != 3) begin bad++; $display("FAIL ldi_rsp_lat got=%0d exp=3", obs_lat); end
    total++; if (obs_data !== 16'h1234 || obs_zero !== 1'b0 || obs_carry !== 1'b0) begin bad++; $display("FAIL ldi_rsp got=%h z%b c%b exp=1234 z0 c0", obs_data, obs_zero, obs_carry); end
    total++; if (rf[3] !== 16'h1234) begin bad++; $display("FAIL ldi_rf3 got=%h exp=1234", rf[3]); end
  endtask

  task automatic test_add_carry();
    run_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    run_cmd(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001);
    run_cmd(OP_ADD, 3'd4, 3'd1, 3'd2, 16'h0000);
    total++; if (obs_we_cnt != 1 || obs_we_addr !== 3'd4 || obs_we_din !== 16'h0000) begin bad++; $display("FAIL add_wb got=%0d %0d/%h exp=1 4/0000", obs_we_cnt, obs_we_addr, obs_we_din); end
    total++; if (obs_data !== 16'h0000 || obs_zero !== 1'b1 || obs_carry !== 1'b1) begin bad++; $display("FAIL add_rsp got=%h z%b c%b exp=0000 z1 c1", obs_data, obs_zero, obs_carry); end
  endtask

  task automatic test_sub_rd();
    run_cmd(OP_SUB, 3'd5, 3'd2, 3'd1, 16'h0000);
    total++; if (obs_data !== 16'h0002 || obs_zero !== 1'b0 || obs_carry !== 1'b1) begin bad++; $display("FAIL sub_rsp got=%h z%b c%b exp=0002 z0 c1", obs_data, obs_zero, obs_carry); end
    total++; if (rf[5] !== 16'h0002) begin bad++; $display("FAIL sub_rf5 got=%h exp=0002", rf[5]); end
    run_cmd(OP_RD, 3'd6, 3'd5, 3'd0, 16'h0000);
    total++; if (obs_data !== 16'h0002 || obs_carry !== 1'b0) begin bad++; $display("FAIL rd_rsp got=%h c%b exp=0002 c0", obs_data, obs_carry); end
    total++; if (obs_we_cnt != 0) begin bad++; $display("FAIL rd_no_write got=%0d exp=0", obs_we_cnt); end
  endtask

  task automatic test_logic();
    run_cmd(OP_AND, 3'd6, 3'd1, 3'd3, 16'h0000);
    total++; if (obs_data !== 16'h1234) begin bad++; $display("FAIL and_rsp got=%h exp=1234", obs_data); end
    run_cmd(OP_OR, 3'd7, 3'd3, 3'd2, 16'h0000);
    total++; if (obs_data !== 16'h1235 || rf[7] !== 16'h1235) begin bad++; $display("FAIL or_rsp got=%h rf7=%h exp=1235", obs_data, rf[7]); end
    run_cmd(OP_MOV, 3'd6, 3'd2, 3'd0, 16'h0000);
    total++; if (obs_data !== 16'h0001 || rf[6] !== 16'h0001) begin bad++; $display("FAIL mov_rsp got=%h rf6=%h exp=0001", obs_data, rf[6]); end
    run_cmd(OP_NOP, 3'd6, 3'd1, 3'd1, 16'hBEEF);
    total++; if (obs_data !== 16'h0000 || obs_zero !== 1'b1 || obs_carry !== 1'b0 || obs_we_cnt != 0) begin bad++; $display("FAIL nop_rsp got=%h z%b c%b we%0d exp=0000 z1 c0 we0", obs_data, obs_zero, obs_carry, obs_we_cnt); end
  endtask

  task automatic test_in_place();
    run_cmd(OP_ADD, 3'd3, 3'd3, 3'd3, 16'h0000);
    total++; if (obs_data !== 16'h2468 || obs_carry !== 1'b0 || rf[3] !== 16'h2468) begin bad++; $display("FAIL inplace got=%h c%b rf3=%h exp=2468 c0", obs_data, obs_carry, rf[3]); end
  endtask

  task automatic test_back_to_back();
    int first_acc;
    run_cmd(OP_LDI, 3'd6, 3'd0, 3'd0, 16'h0007);
    first_acc = acc_cyc;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.cmd_ready); end
    run_cmd(OP_ADD, 3'd6, 3'd6, 3'd6, 16'h0000);
    total++; if (acc_cyc - first_acc != 5) begin bad++; $display("FAIL b2b_spacing got=%0d exp=5", acc_cyc - first_acc); end
    total++; if (obs_data !== 16'h000E || rf[6] !== 16'h000E) begin bad++; $display("FAIL b2b_data got=%h rf6=%h exp=000e", obs_data, rf[6]); end
  endtask

  task automatic test_stall();
    int wr0;
    wr0 = wr_total;
    bus.rsp_ready = 1'b0;
    send_cmd(OP_LDI, 3'd7, 3'd0, 3'd0, 16'h8000);
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_start got=%b exp=1", bus.rsp_valid); end
    bus.cmd_op = OP_LDI; bus.cmd_rd = 3'd1; bus.cmd_ra = 3'd0; bus.cmd_rb = 3'd0; bus.cmd_imm = 16'h0000;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h8000 || bus.cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d] got=v%b %h rdy%b exp=v1 8000 rdy0", i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=v%b rdy%b exp=v0 rdy1", bus.rsp_valid, bus.cmd_ready); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (rf[1] !== 16'hFFFF || wr_total - wr0 != 1) begin bad++; $display("FAIL stall_ignored rf1=%h writes=%0d exp=ffff 1", rf[1], wr_total - wr0); end
  endtask

  task automatic test_clr_mid();
    int wr0;
    wr0 = wr_total;
    send_cmd(OP_ADD, 3'd5, 3'd1, 3'd2, 16'h0000);
    @(posedge clk); #1;
    total++; if (dbg_state !== 3'd2) begin bad++; $display("FAIL clr_pre_state got=%0d exp=2", dbg_state); end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++; if (bus.rf_wr_E !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin bad++; $display("FAIL clr_outputs got=we%b v%b rdy%b st%0d exp=we0 v0 rdy1 st0", bus.rf_wr_E, bus.rsp_valid, bus.cmd_ready, dbg_state); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (bus.rsp_valid !== 1'b0 || wr_total != wr0 || rf[5] !== 16'h0002) begin bad++; $display("FAIL clr_dropped got=v%b writes=%0d rf5=%h exp=v0 0 0002", bus.rsp_valid, wr_total - wr0, rf[5]); end
    run_cmd(OP_RD, 3'd0, 3'd5, 3'd0, 16'h0000);
    total++; if (obs_data !== 16'h0002) begin bad++; $display("FAIL clr_recover got=%h exp=0002", obs_data); end
  endtask

  task automatic test_r0();
    run_cmd(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0005);
`ifdef R0_HARDWIRED_EN
    total++; if (obs_we_cnt != 0 || obs_data !== 16'h0005) begin bad++; $display("FAIL r0_ldi got=we%0d %h exp=we0 0005", obs_we_cnt, obs_data); end
    run_cmd(OP_RD, 3'd1, 3'd0, 3'd0, 16'h0000);
    total++; if (obs_data !== 16'h0000 || obs_zero !== 1'b1) begin bad++; $display("FAIL r0_rd got=%h z%b exp=0000 z1", obs_data, obs_zero); end
`else
    total++; if (obs_we_cnt != 1 || obs_data !== 16'h0005) begin bad++; $display("FAIL r0_ldi got=we%0d %h exp=we1 0005", obs_we_cnt, obs_data); end
    run_cmd(OP_RD, 3'd1, 3'd0, 3'd0, 16'h0000);
    total++; if (obs_data !== 16'h0005 || obs_zero !== 1'b0) begin bad++; $display("FAIL r0_rd got=%h z%b exp=0005 z0", obs_data, obs_zero); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_ra = '0; bus.cmd_rb = '0;
    bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_ldi();
    test_add_carry();
    test_sub_rd();
    test_logic();
    test_in_place();
    test_back_to_back();
    test_stall();
    test_clr_mid();
    test_r0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
